// File: rtl/led_spinner_pwm.sv
// led_spinner_pwm: rotating one-hot LED head with a dimmer trail.
// A prescaler (or a manual strobe) moves the head around a ring of WIDTH LEDs.
// A free-running PWM counter dims both LEDs: the head at the requested brightness,
// the trail at half of it.
module led_spinner_pwm #(
    parameter int WIDTH     = 4,
    parameter int PRESCALE  = 1200000,
    parameter int PWM_BITS  = 4,
    parameter int START_POS = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     dir,
    input  logic                     step_req,
    input  logic [PWM_BITS-1:0]      bright,
    output logic [WIDTH-1:0]         led,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     wrap
);

    localparam int POS_W = $clog2(WIDTH);
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CNT_W-1:0]    r_count;
    logic [POS_W-1:0]    r_pos;
    logic [POS_W-1:0]    r_trail;
    logic                r_trail_valid;
    logic                r_wrap;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_bright_q;
    logic [WIDTH-1:0]    r_led;

    logic                w_tick;
    logic                w_step;
    logic [POS_W-1:0]    w_pos_next;
    logic                w_wrap_next;
    logic                w_head_on;
    logic                w_trail_on;
    logic [WIDTH-1:0]    w_led_next;

    // A tick and a manual strobe in the same cycle merge into a single step.
    assign w_tick = enable && (r_count == CNT_W'(PRESCALE - 1));
    assign w_step = w_tick || step_req;

    // Prescaler: counts only while enabled, rolls over on the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (enable) begin
            if (w_tick) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Next head position around the ring and wrap detection for the chosen direction.
    always_comb begin
        w_pos_next  = r_pos;
        w_wrap_next = 1'b0;
        if (dir == 1'b0) begin
            if (r_pos == POS_W'(WIDTH - 1)) begin
                w_pos_next  = '0;
                w_wrap_next = 1'b1;
            end else begin
                w_pos_next  = r_pos + 1'b1;
            end
        end else begin
            if (r_pos == '0) begin
                w_pos_next  = POS_W'(WIDTH - 1);
                w_wrap_next = 1'b1;
            end else begin
                w_pos_next  = r_pos - 1'b1;
            end
        end
    end

    // Head/trail update on a step; wrap is a one-cycle pulse alongside the new head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos         <= POS_W'(START_POS);
            r_trail       <= POS_W'(START_POS);
            r_trail_valid <= 1'b0;
            r_wrap        <= 1'b0;
        end else begin
            r_wrap <= w_step && w_wrap_next;
            if (w_step) begin
                r_trail       <= r_pos;
                r_trail_valid <= 1'b1;
                r_pos         <= w_pos_next;
            end
        end
    end

    // PWM counter free-runs; brightness is sampled only at the end of a period so a
    // mid-period change never produces a truncated or stretched pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt  <= '0;
            r_bright_q <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (r_pwm_cnt == {PWM_BITS{1'b1}}) begin
                r_bright_q <= bright;
            end
        end
    end

    // Full-scale brightness keeps the head lit across the whole period.
    assign w_head_on  = (r_bright_q == {PWM_BITS{1'b1}}) || (r_pwm_cnt < r_bright_q);
    assign w_trail_on = r_pwm_cnt < (r_bright_q >> 1);

    // Per-LED drive: head or (valid) trail, each gated by its own PWM compare.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_led
            assign w_led_next[gi] = ((r_pos == POS_W'(gi)) && w_head_on) ||
                                    ((r_trail == POS_W'(gi)) && r_trail_valid && w_trail_on);
        end
    endgenerate

    // Register the LED drive so the pins see glitch-free levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_next;
        end
    end

    assign led  = r_led;
    assign pos  = r_pos;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_led_spinner_pwm.sv
// Testbench for led_spinner_pwm: table of manual steps plus directed sequences for
// auto-rotation, coincident tick/strobe, PWM duty/update timing, and async reset.
module tb_led_spinner_pwm;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       dir;
    logic       step_req;
    logic [3:0] bright;
    logic [3:0] led;
    logic [1:0] pos;
    logic       wrap;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;   // rising edges since last reset release (pwm_cnt == cyc % 16)

    led_spinner_pwm #(
        .WIDTH(4), .PRESCALE(4), .PWM_BITS(4), .START_POS(0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .step_req(step_req),
        .bright(bright), .led(led), .pos(pos), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       step;
        logic       dir;
        logic [1:0] exp_pos;
        logic       exp_wrap;
        logic [3:0] exp_led;
        logic [3:0] led_mask;   // trail bit is masked: its PWM phase is not of interest here
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int hcnt, tcnt, stray, p, bq, changes, lows;
        logic new_active;
        logic [1:0] last_pos;
        logic [3:0] exp_led;

        vecs[0]  = '{1'b1, 1'b0, 2'd1, 1'b0, 4'b0001, 4'b1111};
        vecs[1]  = '{1'b0, 1'b0, 2'd1, 1'b0, 4'b0010, 4'b1110};
        vecs[2]  = '{1'b1, 1'b0, 2'd2, 1'b0, 4'b0010, 4'b1110};
        vecs[3]  = '{1'b1, 1'b0, 2'd3, 1'b0, 4'b0100, 4'b1101};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 1'b1, 4'b1000, 4'b1011};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0111};
        vecs[6]  = '{1'b1, 1'b1, 2'd3, 1'b1, 4'b0001, 4'b0111};
        vecs[7]  = '{1'b1, 1'b1, 2'd2, 1'b0, 4'b1000, 4'b1110};
        vecs[8]  = '{1'b1, 1'b1, 2'd1, 1'b0, 4'b0100, 4'b0111};
        vecs[9]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'b0010, 4'b1011};
        vecs[10] = '{1'b0, 1'b0, 2'd1, 1'b0, 4'b0010, 4'b1011};
        vecs[11] = '{1'b1, 1'b0, 2'd2, 1'b0, 4'b0010, 4'b1011};
        vecs[12] = '{1'b0, 1'b0, 2'd2, 1'b0, 4'b0100, 4'b1101};

        rst = 1'b1; enable = 1'b0; dir = 1'b0; step_req = 1'b0; bright = 4'd15;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_pos", pos, 0);
        chk("reset_led", led, 0);
        chk("reset_wrap", wrap, 0);
        rst = 1'b0;
        cyc = 0;

        // Hold with prescaler off: brightness loads, no movement, no trail yet
        repeat (20) tick();
        chk("hold_pos", pos, 0);
        chk("hold_led", led, 4'b0001);

        // Table: manual steps in both directions, enable=0
        for (int i = 0; i < 13; i++) begin
            step_req = vecs[i].step;
            dir      = vecs[i].dir;
            tick();
            $display("vec %0d: step=%0b dir=%0b pos=%0d wrap=%0b led=%b", i,
                     vecs[i].step, vecs[i].dir, pos, wrap, led);
            chk($sformatf("vec%0d_pos", i), pos, vecs[i].exp_pos);
            chk($sformatf("vec%0d_wrap", i), wrap, vecs[i].exp_wrap);
            chk($sformatf("vec%0d_led", i), led & vecs[i].led_mask, vecs[i].exp_led);
        end
        step_req = 1'b0;
        dir      = 1'b0;

        // Auto rotation from pos=2 every 4 clocks, head LED one cycle after pos
        enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("auto%0d_pos", k), pos, (2 + k / 4) % 4);
            chk($sformatf("auto%0d_wrap", k), wrap, (k == 8) ? 1 : 0);
            chk($sformatf("auto%0d_head", k), led[(2 + (k - 1) / 4) % 4], 1);
        end
        enable = 1'b0;
        $display("auto rotation done: pos=%0d", pos);

        // Coincident tick and step_req: exactly one step
        enable = 1'b1;
        repeat (3) tick();
        chk("coin_pre_pos", pos, 2);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        enable   = 1'b0;
        chk("coin_pos", pos, 3);
        chk("coin_wrap", wrap, 0);
        tick();
        chk("coin_hold_pos", pos, 3);
        $display("coincident step: pos=%0d", pos);

        // PWM duty at bright=8: head 8/16, trail 4/16, nothing else lit (head=3, trail=2)
        bright = 4'd8;
        repeat (17) tick();
        hcnt = 0; tcnt = 0; stray = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            hcnt  += int'(led[3]);
            tcnt  += int'(led[2]);
            stray += int'(led[1] | led[0]);
        end
        chk("duty8_head", hcnt, 8);
        chk("duty8_trail", tcnt, 4);
        chk("duty8_stray", stray, 0);
        $display("duty bright=8: head=%0d trail=%0d", hcnt, tcnt);

        // Change bright to 2 mid-period: new duty only from next pwm_cnt==0
        while ((cyc % 16) != 4) tick();
        bright     = 4'd2;
        new_active = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            p = (cyc - 1) % 16;
            if (p == 0) new_active = 1'b1;
            bq = new_active ? 2 : 8;
            exp_led = {logic'(p < bq), logic'(p < (bq >> 1)), 2'b00};
            chk($sformatf("switch%0d_led", i), led, exp_led);
        end
        $display("brightness switch 8->2 checked");

        // bright=0: dark for 64 clocks while the head keeps moving
        bright = 4'd0;
        repeat (20) tick();
        enable   = 1'b1;
        last_pos = pos;
        changes  = 0;
        stray    = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (led != 4'b0000) stray++;
            if (pos != last_pos) changes++;
            last_pos = pos;
        end
        enable = 1'b0;
        chk("dark_led_cycles", stray, 0);
        chk("dark_pos_changes", changes, 16);
        chk("dark_end_pos", pos, 3);
        $display("bright=0: lit cycles=%0d pos changes=%0d", stray, changes);

        // bright=15: head constantly on
        bright = 4'd15;
        repeat (20) tick();
        lows = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (led[3] != 1'b1) lows++;
        end
        chk("full_head_lows", lows, 0);
        $display("bright=15: head low cycles=%0d", lows);

        // Async reset between edges while rotating
        enable = 1'b1;
        repeat (6) tick();
        @(posedge clk);
        #3;
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        chk("async_led", led, 0);
        chk("async_wrap", wrap, 0);
        chk("async_pos", pos, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        repeat (18) tick();
        chk("post_rst_pos", pos, 0);
        chk("post_rst_led", led, 4'b0001);
        chk("post_rst_wrap", wrap, 0);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("post_rst_step_pos", pos, 1);
        chk("post_rst_step_wrap", wrap, 0);
        hcnt = 0; tcnt = 0; stray = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            hcnt  += int'(led[1]);
            tcnt  += int'(led[0]);
            stray += int'(led[3] | led[2]);
        end
        chk("post_rst_head", hcnt, 16);
        chk("post_rst_trail", tcnt, 7);
        chk("post_rst_stray", stray, 0);
        $display("after reset: head=%0d trail=%0d", hcnt, tcnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
